// File: rtl/product_acc_if.sv
// Handshake bundle between the product source, product_accumulator and the result consumer.
// slave is the accumulator side; master is the producer/consumer side.
interface product_acc_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Dot-product stage: sums N_TERMS signed products per frame and hands the sum plus a sticky
// overflow flag downstream. Build option SATURATE_EN clamps each add instead of wrapping.
module product_accumulator #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    product_acc_if.slave  bus,
    output logic          busy
);
    localparam int CNT_W = $clog2(N_TERMS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    ovf, ovf_nxt;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  ext;
    logic signed [ACC_W-1:0]  add_sum;
    logic                     add_ovf;
    logic                     accept;

    // Two's-complement add; overflow when both operands share a sign the result lacks.
    function automatic logic [ACC_W:0] add_term(input logic signed [ACC_W-1:0] a,
                                                input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        logic                    o;
        s = a + b;
        o = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        return {o, s};
    endfunction

`ifdef SATURATE_EN
    // On overflow the true result has the operands' sign, so clamp toward that rail.
    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] s,
                                                         input logic o,
                                                         input logic neg);
        if (!o) return s;
        return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction
`endif

    assign prod             = bus.in_prod;
    assign ext              = ACC_W'(prod);
    assign {add_ovf, add_sum} = add_term(acc, ext);

    assign bus.in_ready  = (state != DONE) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        if (clr) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_nxt   = ext;
                        cnt_nxt   = CNT_W'(1);
                        ovf_nxt   = 1'b0;
                        state_nxt = (N_TERMS == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
`ifdef SATURATE_EN
                        acc_nxt = saturate(add_sum, add_ovf, acc[ACC_W-1]);
`else
                        acc_nxt = add_sum;
`endif
                        ovf_nxt = ovf | add_ovf;
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == CNT_W'(N_TERMS - 1)) state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (defaults, ACC_W=8, N_TERMS=1) driven from
// vector tables, directed corner sequences and random frames against an integer model.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       iv   = '0;
    logic [2:0]       orr  = '0;
    logic [2:0]       cl   = '0;
    logic [2:0][7:0]  ip   = '0;
    logic [2:0]       ir, ov, oo, bz;
    logic [2:0][15:0] os;
    logic             busy_a, busy_b, busy_c;

    int total = 0;
    int bad   = 0;
    int accw [3] = '{16, 8, 16};
    int nterm[3] = '{4, 4, 1};

    product_acc_if #(.PROD_W(8), .ACC_W(16)) ifa ();
    product_acc_if #(.PROD_W(8), .ACC_W(8))  ifb ();
    product_acc_if #(.PROD_W(8), .ACC_W(16)) ifc ();

    product_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(4)) dut_a (
        .clk(clk), .rst(rst), .clr(cl[0]), .bus(ifa.slave), .busy(busy_a));
    product_accumulator #(.PROD_W(8), .ACC_W(8), .N_TERMS(4)) dut_b (
        .clk(clk), .rst(rst), .clr(cl[1]), .bus(ifb.slave), .busy(busy_b));
    product_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(1)) dut_c (
        .clk(clk), .rst(rst), .clr(cl[2]), .bus(ifc.slave), .busy(busy_c));

    assign ifa.in_valid = iv[0];  assign ifa.in_prod = ip[0];  assign ifa.out_ready = orr[0];
    assign ifb.in_valid = iv[1];  assign ifb.in_prod = ip[1];  assign ifb.out_ready = orr[1];
    assign ifc.in_valid = iv[2];  assign ifc.in_prod = ip[2];  assign ifc.out_ready = orr[2];
    assign ir = {ifc.in_ready, ifb.in_ready, ifa.in_ready};
    assign ov = {ifc.out_valid, ifb.out_valid, ifa.out_valid};
    assign oo = {ifc.out_ovf, ifb.out_ovf, ifa.out_ovf};
    assign bz = {busy_c, busy_b, busy_a};
    assign os = {ifc.out_sum, {8'h00, ifb.out_sum}, ifa.out_sum};

    typedef struct {
        int          d;
        logic [7:0]  p0, p1, p2, p3;
        logic [15:0] sum;
        logic        ovf;
        int          hold;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame sum from plain integer arithmetic, folding back into the ACC_W range per add.
    function automatic void model(input logic [7:0] prods[$], input int w,
                                  output logic [15:0] sum, output logic ovf);
        longint s  = 0;
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -mx - 1;
        ovf = 1'b0;
        foreach (prods[i]) begin
            s = s + longint'($signed(prods[i]));
            if (s > mx || s < mn) begin
                ovf = 1'b1;
`ifdef SATURATE_EN
                s = (s > mx) ? mx : mn;
`else
                s = (s > mx) ? s - (mx - mn + 1) : s + (mx - mn + 1);
`endif
            end
        end
        sum = 16'(s);
        if (w == 8) sum[15:8] = 8'h00;
    endfunction

    task automatic push(input int d, input logic [7:0] p, input int gap);
        logic ok;
        int   guard = 0;
        repeat (gap) tick();
        iv[d] = 1'b1;
        ip[d] = p;
        do begin
            ok = ir[d];
            tick();
            guard++;
        end while (!ok && guard < 50);
        iv[d] = 1'b0;
        if (!ok) chk("push_timeout", 16'd0, 16'd1);
    endtask

    task automatic run_frame(input int d, input logic [7:0] prods[$], input logic [15:0] es,
                             input logic eo, input int hold, input int gap_max, input string nm);
        logic [15:0] held;
        foreach (prods[i]) begin
            push(d, prods[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
            if (i == prods.size() - 1) chk({nm, "_valid_latency"}, 16'(ov[d]), 16'd1);
            else                       chk({nm, "_busy_mid"}, 16'({bz[d], ov[d]}), 16'b10);
        end
        held = os[d];
        repeat (hold) begin
            iv[d] = 1'($urandom);
            ip[d] = 8'($urandom);
            chk({nm, "_hold_ready"}, 16'(ir[d]), 16'd0);
            tick();
            chk({nm, "_hold_valid"}, 16'(ov[d]), 16'd1);
            chk({nm, "_hold_sum"}, os[d], held);
        end
        iv[d] = 1'b0;
        chk({nm, "_sum"}, os[d], es);
        chk({nm, "_ovf"}, 16'(oo[d]), 16'(eo));
        orr[d] = 1'b1;
        tick();
        orr[d] = 1'b0;
        chk({nm, "_idle_after"}, 16'({bz[d], ov[d]}), 16'b00);
    endtask

    initial begin
        vec_t        tbl[8];
        logic [7:0]  q[$];
        logic [15:0] es;
        logic        eo;
        logic        was_acc;
        logic [7:0]  p;
        int          nres;

        tbl[0] = '{0, 8'hF1, 8'h31, 8'h09, 8'hE7, 16'h0012, 1'b0, 0};
        tbl[1] = '{0, 8'hF1, 8'h31, 8'h09, 8'hE7, 16'h0012, 1'b0, 5};
        tbl[2] = '{0, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 16'h01FC, 1'b0, 1};
        tbl[3] = '{0, 8'hFF, 8'h01, 8'h80, 8'h7F, 16'hFFFF, 1'b0, 0};
`ifdef SATURATE_EN
        tbl[4] = '{1, 8'h31, 8'h31, 8'h31, 8'h31, 16'h007F, 1'b1, 0};
        tbl[5] = '{1, 8'h80, 8'h80, 8'h80, 8'h80, 16'h0080, 1'b1, 2};
`else
        tbl[4] = '{1, 8'h31, 8'h31, 8'h31, 8'h31, 16'h00C4, 1'b1, 0};
        tbl[5] = '{1, 8'h80, 8'h80, 8'h80, 8'h80, 16'h0000, 1'b1, 2};
`endif
        tbl[6] = '{1, 8'h01, 8'h01, 8'h01, 8'h01, 16'h0004, 1'b0, 0};
        tbl[7] = '{1, 8'hC0, 8'h10, 8'hF0, 8'h20, 16'h00E0, 1'b0, 0};

        repeat (3) tick();
        chk("ready_in_reset", 16'(ir), 16'd0);
        rst = 1'b0;
        tick();
        chk("rst_out_valid", 16'(ov), 16'd0);
        chk("rst_out_ovf", 16'(oo), 16'd0);
        chk("rst_busy", 16'(bz), 16'd0);
        chk("rst_in_ready", 16'(ir), 16'b111);
        for (int k = 0; k < 3; k++) chk("rst_out_sum", os[k], 16'h0000);

        for (int i = 0; i < 8; i++) begin
            q = '{tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3};
            run_frame(tbl[i].d, q, tbl[i].sum, tbl[i].ovf, tbl[i].hold, 0, $sformatf("vec%0d", i));
        end

        // Abort after two accepts; the product offered alongside clr must not land.
        push(0, 8'h10, 0);
        push(0, 8'h20, 0);
        cl[0] = 1'b1; iv[0] = 1'b1; ip[0] = 8'h7F;
        tick();
        cl[0] = 1'b0; iv[0] = 1'b0;
        chk("clr_state", 16'({bz[0], ov[0], oo[0]}), 16'b000);
        chk("clr_sum", os[0], 16'h0000);
        q = '{8'h80, 8'h80, 8'h80, 8'h80};
        run_frame(0, q, 16'hFE00, 1'b0, 0, 0, "after_clr");

        push(1, 8'h31, 0);
        push(1, 8'h31, 0);
        push(1, 8'h31, 0);
        chk("ovf_before_clr", 16'(oo[1]), 16'd1);
        cl[1] = 1'b1;
        tick();
        cl[1] = 1'b0;
        chk("clr_drops_ovf", 16'({oo[1], bz[1]}), 16'b00);

        // Asynchronous reset mid-frame clears outputs without waiting for a clock edge.
        push(0, 8'h40, 0);
        push(0, 8'h40, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sum", os[0], 16'h0000);
        chk("async_rst_ctrl", 16'({bz[0], ov[0], ir[0]}), 16'b000);
        tick();
        rst = 1'b0;
        tick();
        q = '{8'h01, 8'h01, 8'h01, 8'h01};
        run_frame(0, q, 16'h0004, 1'b0, 0, 0, "after_rst");

        q = '{8'h7F};
        run_frame(2, q, 16'h007F, 1'b0, 0, 0, "single");

        // Streaming with out_ready tied high: one result every other cycle.
        orr[2] = 1'b1;
        iv[2]  = 1'b1;
        nres   = 0;
        for (int c = 0; c < 12; c++) begin
            p = 8'($urandom);
            ip[2] = p;
            was_acc = ir[2];
            tick();
            if (was_acc) begin
                nres++;
                chk("stream_valid", 16'(ov[2]), 16'd1);
                chk("stream_sum", os[2], {{8{p[7]}}, p});
            end else begin
                chk("stream_gap", 16'(ov[2]), 16'd0);
            end
        end
        iv[2] = 1'b0;
        tick();
        orr[2] = 1'b0;
        chk("stream_count", 16'(nres), 16'd6);

        for (int f = 0; f < 24; f++) begin
            int d;
            d = (f % 3 == 2) ? 2 : f % 2;
            q.delete();
            for (int k = 0; k < nterm[d]; k++) q.push_back(8'($urandom));
            model(q, accw[d], es, eo);
            run_frame(d, q, es, eo, int'($urandom_range(3, 0)), 2, $sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
